// File: rtl/pixel_stream_tx.sv
// Frame-buffer reader for the corner-detection tap shift registers: raster-order pixel
// stream with a per-row clear pulse, a 2-deep skid buffer and downstream stall support.
module pixel_stream_tx #(
  parameter int IMG_W     = 640,
  parameter int IMG_H     = 480,
  parameter int ADDR_W    = 19,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stall,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_data,
  output logic [7:0]        data,
  output logic              load,
  output logic              row_clr,
  output logic              busy,
  output logic              done
);

  localparam int COL_W = $clog2(IMG_W + 1);
  localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  localparam logic [COL_W-1:0]  COL_END  = COL_W'(IMG_W);
  localparam logic [COL_W-1:0]  COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST = ROW_W'(IMG_H - 1);
  localparam logic [ADDR_W-1:0] ADDR_0   = ADDR_W'(BASE_ADDR);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CLR,
    S_STREAM,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [COL_W-1:0]  rd_col_q, rd_col_d;
  logic [COL_W-1:0]  ld_cnt_q, ld_cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              inflight_q, inflight_d;
  logic [1:0]        occ_q, occ_d;
  logic [7:0]        fifo0_q, fifo0_d;
  logic [7:0]        fifo1_q, fifo1_d;
  logic              load_q, load_d;
  logic [7:0]        data_q, data_d;

  logic              rd_ok;
  logic              take;
  logic              push;
  logic              pop;
  logic              row_last_load;
  logic [1:0]        wr_slot;

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    rd_col_d   = rd_col_q;
    ld_cnt_d   = ld_cnt_q;
    addr_d     = addr_q;
    mem_rd     = 1'b0;
    row_clr    = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;

    // Budget counts the read returning this cycle, so at most 2 pixels are ever owed.
    rd_ok = (state_q == S_STREAM) && (rd_col_q != COL_END) &&
            ((occ_q + {1'b0, inflight_q}) < 2'd2);
    row_last_load = load_q && (ld_cnt_q == COL_LAST);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_CLR;
          row_d   = '0;
          addr_d  = ADDR_0;
        end
      end
      S_CLR: begin
        row_clr  = 1'b1;
        busy     = 1'b1;
        rd_col_d = '0;
        ld_cnt_d = '0;
        state_d  = S_STREAM;
      end
      S_STREAM: begin
        busy   = 1'b1;
        mem_rd = rd_ok;
        if (rd_ok) begin
          addr_d   = addr_q + ADDR_W'(1);
          rd_col_d = rd_col_q + COL_W'(1);
        end
        if (load_q) begin
          ld_cnt_d = ld_cnt_q + COL_W'(1);
        end
        // Leave only once the row's final pixel has actually been loaded downstream.
        if (row_last_load) begin
          if (row_q == ROW_LAST) begin
            state_d = S_DONE;
          end else begin
            row_d   = row_q + ROW_W'(1);
            state_d = S_CLR;
          end
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    inflight_d = mem_rd;
    fifo0_d    = fifo0_q;
    fifo1_d    = fifo1_q;
    occ_d      = occ_q;
    data_d     = data_q;

    take    = !stall && ((occ_q != 2'd0) || inflight_q);
    pop     = take && (occ_q != 2'd0);
    push    = inflight_q && !(take && (occ_q == 2'd0));
    wr_slot = pop ? (occ_q - 2'd1) : occ_q;
    load_d  = take;

    if (take) begin
      data_d = (occ_q != 2'd0) ? fifo0_q : mem_data;
    end
    if (pop) begin
      fifo0_d = fifo1_q;
    end
    if (push) begin
      if (wr_slot == 2'd0) begin
        fifo0_d = mem_data;
      end else begin
        fifo1_d = mem_data;
      end
    end
    occ_d = occ_q + {1'b0, push} - {1'b0, pop};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      row_q      <= '0;
      rd_col_q   <= '0;
      ld_cnt_q   <= '0;
      addr_q     <= '0;
      inflight_q <= 1'b0;
      occ_q      <= 2'd0;
      load_q     <= 1'b0;
      data_q     <= 8'd0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      rd_col_q   <= rd_col_d;
      ld_cnt_q   <= ld_cnt_d;
      addr_q     <= addr_d;
      inflight_q <= inflight_d;
      occ_q      <= occ_d;
      load_q     <= load_d;
      data_q     <= data_d;
    end
  end

  // Skid storage is qualified by occ_q, so its contents need no reset.
  always_ff @(posedge clk) begin
    fifo0_q <= fifo0_d;
    fifo1_q <= fifo1_d;
  end

  assign mem_addr = mem_rd ? addr_q : '0;
  assign data     = data_q;
  assign load     = load_q;

endmodule

// File: tb/tb_pixel_stream_tx.sv
// Scoreboard bench for pixel_stream_tx on a 4x2 frame with mem[a] = a + 16.
module tb_pixel_stream_tx;

  localparam int IMG_W  = 4;
  localparam int IMG_H  = 2;
  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic              stall = 1'b0;
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_data = 8'hEE;
  logic [7:0]        data;
  logic              load;
  logic              row_clr;
  logic              busy;
  logic              done;

  pixel_stream_tx #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W), .BASE_ADDR(0)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .stall(stall),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_data(mem_data),
    .data(data), .load(load), .row_clr(row_clr), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) mem_data <= mem_rd ? (mem_addr + 8'd16) : 8'hEE;

  typedef struct {
    int val;
    int cyc;
  } exp_t;

  exp_t ld_q[$];
  exp_t rd_q[$];
  int   rc_q[$];
  int   exp_done;
  int   ld_c[8];
  int   rd_c[8];
  int   rc_c[2];

  int   errors = 0;
  int   checks = 0;
  bit   mon_en = 1'b0;
  int   t0 = 0;
  int   done_seen;
  int   busy_cnt;
  int   pend;
  bit   stall_prev;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (time %0t)", name, act, exp, $time);
    end
  endtask

  int   mrel;
  exp_t me;
  int   mrc;
  always @(negedge clk) begin
    if (mon_en) begin
      mrel = cyc - t0;
      if (mem_rd) begin
        pend++;
        if (rd_q.size() == 0) begin
          chk("extra_read_addr", int'(mem_addr), -1);
        end else begin
          me = rd_q.pop_front();
          chk("read_addr", int'(mem_addr), me.val);
          chk("read_cycle", mrel, me.cyc);
        end
      end
      if (load) begin
        pend--;
        if (ld_q.size() == 0) begin
          chk("extra_load_data", int'(data), -1);
        end else begin
          me = ld_q.pop_front();
          chk("load_data", int'(data), me.val);
          chk("load_cycle", mrel, me.cyc);
        end
      end
      if (mem_rd) chk("pending_le_2", int'(pend <= 2), 1);
      if (stall_prev) chk("load_after_stall", int'(load), 0);
      if (row_clr) begin
        chk("row_clr_with_load", int'(load), 0);
        if (rc_q.size() == 0) begin
          chk("extra_row_clr_cycle", mrel, -1);
        end else begin
          mrc = rc_q.pop_front();
          chk("row_clr_cycle", mrel, mrc);
        end
      end
      if (done) begin
        chk("done_cycle", mrel, exp_done);
        done_seen++;
      end
      if (busy) busy_cnt++;
      stall_prev = stall;
    end
  end

  task automatic push_exp(input int n_ld, input int n_rd, input int n_rc, input int d);
    exp_t e;
    ld_q.delete();
    rd_q.delete();
    rc_q.delete();
    for (int i = 0; i < n_ld; i++) begin
      e.val = 16 + i;
      e.cyc = ld_c[i];
      ld_q.push_back(e);
    end
    for (int i = 0; i < n_rd; i++) begin
      e.val = i;
      e.cyc = rd_c[i];
      rd_q.push_back(e);
    end
    for (int i = 0; i < n_rc; i++) rc_q.push_back(rc_c[i]);
    exp_done = d;
  endtask

  task automatic run(input int s_lo, input int s_hi, input int st2, input int st3,
                     input int rst_at, input int exp_busy);
    int n;
    pend       = 0;
    done_seen  = 0;
    busy_cnt   = 0;
    stall_prev = 1'b0;
    n = (rst_at >= 0) ? rst_at : exp_done + 6;
    @(posedge clk);
    #1;
    t0     = cyc;
    mon_en = 1'b1;
    for (int rel = 0; rel < n; rel++) begin
      start = (rel == 0) || (rel == st2) || (rel == st3);
      stall = (rel >= s_lo) && (rel <= s_hi);
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    stall = 1'b0;
    if (rst_at >= 0) begin
      mon_en = 1'b0;
      reset  = 1'b0;
      #1;
      chk("async_rst_mem_rd", int'(mem_rd), 0);
      chk("async_rst_mem_addr", int'(mem_addr), 0);
      chk("async_rst_load", int'(load), 0);
      chk("async_rst_data", int'(data), 0);
      chk("async_rst_busy", int'(busy), 0);
      chk("async_rst_row_clr", int'(row_clr), 0);
      chk("async_rst_done", int'(done), 0);
      repeat (3) begin
        @(negedge clk);
        chk("in_rst_mem_rd", int'(mem_rd), 0);
        chk("in_rst_load", int'(load), 0);
      end
      @(posedge clk);
      #1;
      reset = 1'b1;
      repeat (3) begin
        @(negedge clk);
        chk("post_rst_idle_load", int'(load), 0);
        chk("post_rst_idle_busy", int'(busy), 0);
      end
    end else begin
      mon_en = 1'b0;
      chk("done_count", done_seen, 1);
      chk("busy_cycles", busy_cnt, exp_busy);
    end
    chk("loads_outstanding", ld_q.size(), 0);
    chk("reads_outstanding", rd_q.size(), 0);
    chk("row_clr_outstanding", rc_q.size(), 0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_mem_rd", int'(mem_rd), 0);
    chk("reset_load", int'(load), 0);
    chk("reset_data", int'(data), 0);
    chk("reset_row_clr", int'(row_clr), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);

    // Baseline frame, no stall.
    ld_c = '{4, 5, 6, 7, 11, 12, 13, 14};
    rd_c = '{2, 3, 4, 5, 9, 10, 11, 12};
    rc_c = '{1, 8};
    push_exp(8, 8, 2, 15);
    run(-1, -2, -1, -1, -1, 14);

    // Stall in cycles 5-7.
    ld_c = '{4, 5, 9, 10, 14, 15, 16, 17};
    rd_c = '{2, 3, 4, 5, 12, 13, 14, 15};
    rc_c = '{1, 11};
    push_exp(8, 8, 2, 18);
    run(5, 7, -1, -1, -1, 17);

    // Long stall from the start: only two reads run ahead.
    ld_c = '{22, 23, 24, 25, 29, 30, 31, 32};
    rd_c = '{2, 3, 22, 23, 27, 28, 29, 30};
    rc_c = '{1, 26};
    push_exp(8, 8, 2, 33);
    run(0, 20, -1, -1, -1, 32);

    // Asynchronous reset in cycle 6, then a clean restart.
    ld_c = '{4, 5, 6, 7, 11, 12, 13, 14};
    rd_c = '{2, 3, 4, 5, 9, 10, 11, 12};
    rc_c = '{1, 8};
    push_exp(2, 4, 1, -1);
    run(-1, -2, -1, -1, 6, 0);
    push_exp(8, 8, 2, 15);
    run(-1, -2, -1, -1, -1, 14);

    // start re-pulsed while busy and in DONE.
    push_exp(8, 8, 2, 15);
    run(-1, -2, 3, 15, -1, 14);

    // Stall hits the final pixel only.
    ld_c = '{4, 5, 6, 7, 11, 12, 13, 15};
    push_exp(8, 8, 2, 16);
    run(13, 13, -1, -1, -1, 15);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
